// File: rtl/nibble_pack_fifo.sv
// nibble_pack_fifo: pairs consecutive valid nibbles from the upstream
// pipeline into bytes ({second, first}) and buffers them in a small FIFO
// drained over valid/ready. The input side never stalls; a byte that
// completes while the FIFO cannot take it is dropped and flagged.
module nibble_pack_fifo #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    in_nibble,
  input  logic          in_valid,
  input  logic          flush,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_t;

  pack_state_t   state;
  pack_state_t   state_nxt;
  logic [3:0]    lo_reg;
  logic [3:0]    lo_nxt;
  logic          push;
  logic [7:0]    push_byte;
  logic          pop;
  logic          push_ok;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [7:0]    mem [DEPTH];

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = out_valid & out_ready;
  // A full FIFO still accepts a byte when the head leaves at the same edge.
  assign push_ok   = push & (~full | pop);
  assign out_data  = mem[rd_ptr];

  // Packer next-state: hold the first nibble, emit a byte on the second.
  always_comb begin
    state_nxt = state;
    lo_nxt    = lo_reg;
    push      = 1'b0;
    push_byte = {in_nibble, lo_reg};
    if (in_valid) begin
      case (state)
        EMPTY: begin
          lo_nxt    = in_nibble;
          state_nxt = HALF;
        end
        HALF: begin
          push      = 1'b1;
          state_nxt = EMPTY;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Packer state register; flush discards any held nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      lo_reg <= 4'h0;
    end else if (flush) begin
      state  <= EMPTY;
    end else begin
      state  <= state_nxt;
      lo_reg <= lo_nxt;
    end
  end

  // FIFO pointers, occupancy and sticky overflow; flush overrides all traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push_ok) begin
        count <= count - CW'(1);
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  // Byte storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_byte;
    end
  end

endmodule

// File: tb/tb_nibble_pack_fifo.sv
// Bench for nibble_pack_fifo: a queue-based reference model advanced once
// per driven cycle, a negedge monitor comparing DUT status against it, and
// directed sequences plus randomized traffic.
module tb_nibble_pack_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    in_nibble = 4'h0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;

  nibble_pack_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_nibble (in_nibble),
    .in_valid  (in_valid),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stored bytes, held nibble, sticky drop flag.
  logic [7:0] exp_q[$];
  bit         m_half = 1'b0;
  logic [3:0] m_lo   = 4'h0;
  bit         m_ovf  = 1'b0;

  // Bytes actually handed to the consumer, and a directed expectation list.
  logic [7:0] got_q[$];
  logic [7:0] want_q[$];

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_half = 1'b0;
    m_lo   = 4'h0;
    m_ovf  = 1'b0;
  endfunction

  // Effect of one clock edge with the given inputs, from the block's rules.
  function automatic void model_step(bit v, logic [3:0] nib, bit rdy, bit fl);
    bit         do_pop;
    bit         was_full;
    bit         have_byte;
    logic [7:0] b;
    if (fl) begin
      exp_q.delete();
      m_half = 1'b0;
      m_ovf  = 1'b0;
      return;
    end
    do_pop    = rdy && (exp_q.size() != 0);
    was_full  = (exp_q.size() == DEPTH);
    have_byte = 1'b0;
    b         = 8'h00;
    if (v) begin
      if (!m_half) begin
        m_lo   = nib;
        m_half = 1'b1;
      end else begin
        b         = {nib, m_lo};
        have_byte = 1'b1;
        m_half    = 1'b0;
      end
    end
    if (do_pop) void'(exp_q.pop_front());
    if (have_byte) begin
      if (!was_full || do_pop) exp_q.push_back(b);
      else m_ovf = 1'b1;
    end
  endfunction

  // One clock of stimulus, applied well after the falling edge.
  task automatic drive(bit v, logic [3:0] nib, bit rdy, bit fl);
    @(negedge clk);
    #1;
    if (rdy && out_valid && !fl) got_q.push_back(out_data);
    in_valid  = v;
    in_nibble = nib;
    out_ready = rdy;
    flush     = fl;
    model_step(v, nib, rdy, fl);
  endtask

  task automatic idle(int n, bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, rdy, 1'b0);
  endtask

  task automatic check_got(string name);
    chk({name, "_len"}, got_q.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
      chk(name, got_q[i], want_q[i]);
    got_q.delete();
  endtask

  task automatic check_reset_outputs(string name);
    chk({name, "_count"}, count, 0);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_full"}, full, 0);
    chk({name, "_overflow"}, overflow, 0);
  endtask

  // Asynchronous reset in the middle of a high clock phase.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    got_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: status and head byte must always match the reference model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mon_count", count, exp_q.size());
      chk("mon_out_valid", out_valid, exp_q.size() != 0);
      chk("mon_full", full, exp_q.size() == DEPTH);
      chk("mon_overflow", overflow, m_ovf);
      if (exp_q.size() != 0) chk("mon_out_data", out_data, exp_q[0]);
    end
  end

  initial begin
    #1;
    check_reset_outputs("reset_initial");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Pairing with the consumer always ready.
    drive(1'b1, 4'h3, 1'b1, 1'b0);
    drive(1'b1, 4'hA, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("pair_valid", out_valid, 1);
    chk("pair_data", out_data, 8'hA3);
    idle(1, 1'b1);
    chk("pair_count_after_pop", count, 0);
    want_q = '{8'hA3};
    check_got("pair_seq");

    // Gapped input: lone nibble waits across idle cycles.
    drive(1'b1, 4'h5, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("gap_no_output", out_valid, 0);
    drive(1'b1, 4'hC, 1'b1, 1'b0);
    idle(3, 1'b1);
    want_q = '{8'hC5};
    check_got("gap_seq");

    // Fill past capacity with the consumer stalled.
    for (int i = 0; i < 10; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("fill_count", count, 4);
    chk("fill_full", full, 1);
    chk("fill_overflow", overflow, 1);
    idle(6, 1'b1);
    want_q = '{8'h10, 8'h32, 8'h54, 8'h76};
    check_got("fill_drain");

    // Full FIFO with a pop on the same edge a byte completes.
    drive(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
    drive(1'b1, 4'h9, 1'b1, 1'b0);
    idle(1, 1'b0);
    chk("fullpop_count", count, 4);
    chk("fullpop_overflow", overflow, 0);
    idle(6, 1'b1);
    want_q = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98};
    check_got("fullpop_drain");

    // Flush with two bytes stored, overflow set and a nibble held.
    for (int i = 0; i < 10; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
    idle(2, 1'b1);
    drive(1'b1, 4'hE, 1'b0, 1'b0);
    idle(1, 1'b0);
    chk("preflush_count", count, 2);
    chk("preflush_overflow", overflow, 1);
    got_q.delete();
    drive(1'b1, 4'hF, 1'b1, 1'b1);
    idle(1, 1'b0);
    chk("flush_count", count, 0);
    chk("flush_overflow", overflow, 0);
    drive(1'b1, 4'h1, 1'b1, 1'b0);
    drive(1'b1, 4'h2, 1'b1, 1'b0);
    idle(3, 1'b1);
    want_q = '{8'h21};
    check_got("flush_seq");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) < 4, $urandom_range(0, 59) == 0);
    end

    // Reset mid-operation with a nibble held: no partial byte afterwards.
    drive(1'b1, 4'h4, 1'b0, 1'b0);
    drive(1'b1, 4'h6, 1'b0, 1'b0);
    drive(1'b1, 4'h8, 1'b0, 1'b0);
    mid_reset();
    drive(1'b1, 4'h7, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("post_reset_no_partial", out_valid, 0);
    drive(1'b1, 4'hB, 1'b1, 1'b0);
    idle(3, 1'b1);
    want_q = '{8'hB7};
    check_got("post_reset_seq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
